// File: rtl/bin_morph_3x3.sv
// Streaming 3x3 binary morphology (AND or OR reduction) over a raster-order 1-bit edge map.
// Two line buffers feed a 3x3 window; windows straddling the frame top or a line wrap are masked.
module bin_morph_3x3 #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned MODE  = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        bin_en,
    input  logic        bin_in,
    input  logic        frame_start,
    output logic        morph_wr_en,
    output logic        morph_1bit,
    output logic [15:0] morph_data
);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, cur_col, col_s1_q;
    logic [RW-1:0] row_q, row_d, cur_row, row_s1_q;
    logic          lb1_q [IMG_W];
    logic          lb2_q [IMG_W];
    logic          lb1_rd, lb2_rd;
    // win_q[0] is the oldest column; bit 2 is the top row (row-2).
    logic [2:0]    win_q [3];
    logic          en_s1_q, wr_en_q, bit_q;
    logic          red, result;

    always_comb begin
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (bin_en) begin
            if (cur_col == ColLast) begin
                col_d = '0;
                row_d = (cur_row == RowLast) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end else if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end
    end

    assign lb1_rd = lb1_q[cur_col];
    assign lb2_rd = lb2_q[cur_col];

    // Line buffers are deliberately not reset; the border mask hides stale rows.
    always_ff @(posedge sys_clk) begin
        if (bin_en) begin
            lb1_q[cur_col] <= bin_in;
            lb2_q[cur_col] <= lb1_rd;
        end
    end

    always_comb begin
        if (MODE != 0) begin
            red = |{win_q[0], win_q[1], win_q[2]};
        end else begin
            red = &{win_q[0], win_q[1], win_q[2]};
        end
        result = ((row_s1_q < RW'(2)) || (col_s1_q < CW'(2))) ? 1'b1 : red;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            col_s1_q <= '0;
            row_s1_q <= '0;
            win_q[0] <= '1;
            win_q[1] <= '1;
            win_q[2] <= '1;
            en_s1_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            en_s1_q <= bin_en;
            wr_en_q <= en_s1_q;
            if (bin_en) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= {lb2_rd, lb1_rd, bin_in};
                col_s1_q <= cur_col;
                row_s1_q <= cur_row;
            end
            if (en_s1_q) begin
                bit_q <= result;
            end
        end
    end

    assign morph_wr_en = wr_en_q;
    assign morph_1bit  = bit_q;
    assign morph_data  = {16{bit_q}};

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Directed bench for bin_morph_3x3 on an 8x6 frame, one instance per reduction mode.
module tb_bin_morph_3x3;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        bin_en = 1'b0;
    logic        bin_in = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr0, b0, wr1, b1;
    logic [15:0] d0, d1;

    int checks = 0;
    int errors = 0;
    int lat_bad = 0;
    int base0, base1;
    logic        q0[$];
    logic        q1[$];
    logic [15:0] qd0[$];
    logic [15:0] qd1[$];
    logic        eh1 = 1'b0;
    logic        eh2 = 1'b0;

    always #5 sys_clk = ~sys_clk;

    bin_morph_3x3 #(.IMG_W(W), .IMG_H(H), .MODE(0)) dut0 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .bin_en      (bin_en),
        .bin_in      (bin_in),
        .frame_start (frame_start),
        .morph_wr_en (wr0),
        .morph_1bit  (b0),
        .morph_data  (d0)
    );

    bin_morph_3x3 #(.IMG_W(W), .IMG_H(H), .MODE(1)) dut1 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .bin_en      (bin_en),
        .bin_in      (bin_in),
        .frame_start (frame_start),
        .morph_wr_en (wr1),
        .morph_1bit  (b1),
        .morph_data  (d1)
    );

    // Output capture plus the two-cycle bin_en -> morph_wr_en relationship.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            eh1 <= 1'b0;
            eh2 <= 1'b0;
        end else begin
            if (wr0 !== eh2 || wr1 !== eh2) lat_bad <= lat_bad + 1;
            if (wr0) begin
                q0.push_back(b0);
                qd0.push_back(d0);
            end
            if (wr1) begin
                q1.push_back(b1);
                qd1.push_back(d1);
            end
            eh1 <= bin_en;
            eh2 <= eh1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic pix(input int kind, input int r, input int c);
        logic hit;
        hit = (r == 3 && c == 3);
        case (kind)
            0: return 1'b1;
            1: return !hit;
            2: return hit;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_bit(input int kind, input int r, input int c);
        logic in9;
        in9 = (r >= 3 && r <= 5 && c >= 3 && c <= 5);
        case (kind)
            0: return 1'b1;
            1: return !in9;
            2: return in9 || r < 2 || c < 2;
            default: return r < 2 || c < 2;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic beat(input logic b, input logic fs);
        bin_en = 1'b1;
        bin_in = b;
        frame_start = fs;
        @(posedge sys_clk);
        #1;
        bin_en = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input int kind, input int maxgap, input logic fs);
        for (int k = 0; k < N; k++) begin
            beat(pix(kind, k / W, k % W), fs && (k == 0));
            if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
        end
        idle(4);
    endtask

    task automatic check_frame(input string tag, input int mode, input int base, input int kind);
        int n;
        logic got;
        logic [15:0] gotd;
        logic e;
        n = (mode == 0) ? q0.size() : q1.size();
        chk($sformatf("%s count", tag), 16'(n - base), 16'(N));
        for (int k = 0; k < N; k++) begin
            if (base + k >= n) break;
            got  = (mode == 0) ? q0[base + k] : q1[base + k];
            gotd = (mode == 0) ? qd0[base + k] : qd1[base + k];
            e    = exp_bit(kind, k / W, k % W);
            chk($sformatf("%s bit%0d", tag, k), 16'(got), 16'(e));
            chk($sformatf("%s data%0d", tag, k), gotd, e ? 16'hFFFF : 16'h0000);
        end
    endtask

    initial begin
        #1 sys_rst_n = 1'b0;
        #1;
        chk("rst wr_en", 16'(wr0), 16'h0);
        chk("rst bit", 16'(b0), 16'h0);
        chk("rst data", d0, 16'h0000);
        idle(2);
        sys_rst_n = 1'b1;
        idle(1);

        base0 = q0.size();
        send_frame(0, 0, 1'b0);
        check_frame("ones", 0, base0, 0);

        base0 = q0.size();
        send_frame(1, 0, 1'b0);
        check_frame("zero", 0, base0, 1);

        base1 = q1.size();
        send_frame(2, 0, 1'b0);
        check_frame("one_m1", 1, base1, 2);

        base0 = q0.size();
        send_frame(1, 5, 1'b0);
        check_frame("burst", 0, base0, 1);

        // 19 beats, then frame_start rides on the 20th beat.
        for (int k = 0; k < 19; k++) beat(1'b1, 1'b0);
        idle(3);
        base0 = q0.size();
        send_frame(3, 0, 1'b1);
        check_frame("fstart", 0, base0, 3);

        for (int k = 0; k < 30; k++) beat(1'b1, 1'b0);
        chk("pre_rst wr_en", 16'(wr0), 16'h1);
        sys_rst_n = 1'b0;
        #1;
        chk("async wr_en", 16'(wr0), 16'h0);
        chk("async bit", 16'(b0), 16'h0);
        chk("async data", d0, 16'h0000);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        idle(2);
        base0 = q0.size();
        send_frame(3, 0, 1'b0);
        check_frame("post_rst zeros", 0, base0, 3);
        base0 = q0.size();
        send_frame(0, 0, 1'b0);
        check_frame("post_rst ones", 0, base0, 0);

        chk("latency", 16'(lat_bad), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin_morph_3x3.md
# bin_morph_3x3

Streaming 3×3 binary morphology stage for the edge-detection path. It consumes the 1-bit edge map produced by the Sobel stage, in raster order, one pixel per valid beat. It applies a 3×3 AND (edge dilate) or OR (edge erode) over a window built from two internal line buffers, and emits a cleaned 1-bit map plus an RGB565-width black/white word toward the display/SDRAM write path. The stage has no back-pressure; it tracks frame position internally so that border windows are masked.

## Interface
- IMG_W, 640, pixels per line; line buffer depth.
- IMG_H, 480, lines per frame.
- MODE, 0, 0 = out is AND of 9 bits (edge pixels, value 0, grow); 1 = out is OR of 9 bits (edge pixels shrink).
- sys_clk  in  1  sole clock; all logic is on the rising edge.
- sys_rst_n  in  1  reset, asynchronous and active-low.
- bin_en  in  1  input beat valid; one pixel per cycle when high.
- bin_in  in  1  edge bit (0 = edge/black, 1 = background/white).
- frame_start  in  1  synchronous pulse; restarts position counters (see Operation).
- morph_wr_en  out  1  output beat valid.
- morph_1bit  out  1  filtered bit.
- morph_data  out  16  16'hFFFF when morph_1bit = 1, otherwise 16'h0000.

## Operation
- **Position counters:** col counts 0..IMG_W-1 and row counts 0..IMG_H-1, each $clog2 wide. Both advance only on beats where bin_en = 1.
  - col wraps to 0 at IMG_W-1 and row increments on that wrap.
  - row wraps to 0 after IMG_H-1, col IMG_W-1.
- **frame_start:**
  - frame_start = 1 with bin_en = 1: the current beat is pixel (0,0), and the counters become col = 1, row = 0.
  - frame_start = 1 with bin_en = 0: the counters clear to (0,0).
  - frame_start takes priority over the normal increment. Line-buffer contents are not cleared.
- **Line buffers:** two IMG_W×1 memories indexed by col (LB1 holds row-1, LB2 holds row-2). On each beat:
  - read LB1[col] and LB2[col];
  - write LB2[col] ← LB1[col] and LB1[col] ← bin_in.
- **Window:** 3×3 register array. On each beat, every column shifts left and the new right column is {LB2[col], LB1[col], bin_in}. The beat's position (row, col) is registered with the window.
- **Reduction:**
  - MODE 0: AND of the 9 bits.
  - MODE 1: OR of the 9 bits.
  - Border mask: if the registered row < 2 or col < 2, the result is forced to 1 (background), because the window straddles the frame top or a line wrap.
- **Output mapping:** the output beat for input beat at position (r,c) is the result for the window centred on (r-1,c-1). Output count equals input count.
- **Idle behaviour:** when bin_en = 0, nothing shifts or advances, morph_wr_en is 0, and morph_1bit/morph_data hold their last values.

## Timing
- **Latency:** input beat at cycle t produces morph_wr_en = 1 at cycle t+2, with morph_1bit/morph_data valid in that same cycle.
  - Stage 1 (t+1): window/position registers.
  - Stage 2 (t+2): reduction and output registers.
- morph_wr_en is bin_en delayed by exactly 2 cycles, independent of the data.
- Gaps in bin_en stall the data path but never reorder or drop beats.
- **Reset:** while sys_rst_n = 0, the following values apply immediately (asynchronously) and hold until the first beat after release:
  - morph_wr_en = 0, morph_1bit = 0, morph_data = 16'h0000;
  - window bits = 1, counters = 0, enable pipeline = 0.
- **Reset mid-frame:** the in-flight beats are lost, and the next beat after release is treated as (0,0).
- Line buffers are not reset; the border mask hides stale contents for rows 0–1 of every frame.
- **Back-to-back frames:** with no frame_start, the row wrap alone restarts masking.

## Test plan
Benches use IMG_W = 8, IMG_H = 6.
- **All-ones frame, MODE 0:** 48 beats with bin_in = 1 → 48 outputs, all morph_1bit = 1 and morph_data = 16'hFFFF. Each morph_wr_en occurs exactly 2 cycles after its bin_en.
- **Single zero, MODE 0:** bin_in = 0 only at (3,3) → morph_1bit = 0 exactly at output indices r·8+c for r, c ∈ {3,4,5} (9 beats); all others are 1.
- **Single one, MODE 1:** all zeros except a 1 at (3,3) → outputs are 1 at those same 9 indices and at every index with r < 2 or c < 2; all remaining outputs are 0.
- **Bursty input:** scenario 2 with random bin_en gaps of 0–5 cycles → identical output sequence. morph_wr_en is never high without a beat 2 cycles earlier.
- **frame_start mid-frame:** assert frame_start with the 20th beat, then send a full frame of zeros in MODE 0 → the first 16 outputs from that point, and every c < 2 output, are 1; all others are 0.
- **Reset mid-frame:** pulse sys_rst_n low for 1 cycle at beat 30 → outputs go to 0/0/16'h0000 asynchronously. The next beat after release is masked as (0,0) and the following frame matches scenario 1.
